// File: rtl/rider_steer_qual.sv
// Rider-presence and steering-enable qualifier: sums/differences the load cells,
// applies weight hysteresis, balance limits and a steady-time qualifier.
module rider_steer_qual #(
  parameter int LD_W         = 12,
  parameter int MIN_RIDER_WT = 'h200,
  parameter int WT_HYST      = 'h40,
  parameter int TMR_W        = 26,
  parameter int FAST_SIM     = 0,
  parameter int ENTER_SHIFT  = 2,
  parameter int EXIT_NUM     = 15,
  parameter int EXIT_SHIFT   = 4,
  parameter int OFF_DBNC     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      steer_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_STEER   = 2'd2
  } state_t;

  localparam int CNT_W      = $clog2(OFF_DBNC + 1);
  localparam int LO_THR_I   = MIN_RIDER_WT - WT_HYST;
  localparam int HI_THR_I   = MIN_RIDER_WT + WT_HYST;
  localparam int CNT_LAST_I = OFF_DBNC - 1;

  localparam logic [LD_W:0]    LO_THR     = LO_THR_I[LD_W:0];
  localparam logic [LD_W:0]    HI_THR     = HI_THR_I[LD_W:0];
  localparam logic [LD_W:0]    EXIT_NUM_V = EXIT_NUM[LD_W:0];
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_LAST_I[CNT_W-1:0];

  logic [LD_W:0]    w_sum;
  logic [LD_W-1:0]  w_abs;
  logic [LD_W:0]    r_sum;
  logic [LD_W-1:0]  r_abs;
  logic [LD_W:0]    r_enterLim;
  logic [LD_W:0]    r_exitLim;

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_offCnt;
  logic [CNT_W-1:0] w_offNext;

  logic w_ltMin;
  logic w_gtMin;
  logic w_badEnter;
  logic w_badExit;
  logic w_riderLost;
  logic w_tmrFull;

  // Magnitude is taken by ordering the operands so unsigned inputs never wrap.
  assign w_sum = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign w_abs = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_abs      <= '0;
      r_enterLim <= '0;
      r_exitLim  <= '0;
    end else begin
      r_sum      <= w_sum;
      r_abs      <= w_abs;
      r_enterLim <= w_sum >> ENTER_SHIFT;
      r_exitLim  <= (w_sum >> EXIT_SHIFT) * EXIT_NUM_V;
    end
  end

  assign w_ltMin     = r_sum < LO_THR;
  assign w_gtMin     = r_sum > HI_THR;
  assign w_badEnter  = {1'b0, r_abs} > r_enterLim;
  assign w_badExit   = {1'b0, r_abs} > r_exitLim;
  assign w_riderLost = w_ltMin && (r_offCnt == CNT_LAST);
  assign w_offNext   = w_ltMin ? (r_offCnt + 1'b1) : '0;
  assign w_tmrFull   = (FAST_SIM != 0) ? (&r_tmr[14:0]) : (&r_tmr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tmr    <= '0;
      r_offCnt <= '0;
    end else begin
      r_tmr <= r_tmr + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_offCnt <= '0;
          if (w_gtMin) begin
            r_state <= ST_QUALIFY;
            r_tmr   <= '0;
          end
        end
        ST_QUALIFY: begin
          if (w_riderLost) begin
            r_state  <= ST_IDLE;
            r_offCnt <= '0;
          end else if (w_badEnter) begin
            r_tmr    <= '0;
            r_offCnt <= w_offNext;
          end else if (w_tmrFull) begin
            r_state  <= ST_STEER;
            r_offCnt <= '0;
          end else begin
            r_offCnt <= w_offNext;
          end
        end
        ST_STEER: begin
          if (w_riderLost) begin
            r_state  <= ST_IDLE;
            r_offCnt <= '0;
          end else if (w_badExit) begin
            r_state  <= ST_QUALIFY;
            r_tmr    <= '0;
            r_offCnt <= '0;
          end else begin
            r_offCnt <= w_offNext;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_offCnt <= '0;
        end
      endcase
    end
  end

  assign en_steer    = (r_state == ST_STEER);
  assign rider_off   = (r_state == ST_IDLE);
  assign steer_state = r_state;

endmodule

// File: tb/tb_rider_steer_qual.sv
// Directed self-checking bench for rider_steer_qual; a second instance is used
// only to observe a reset taken while steering.
module tb_rider_steer_qual;

  logic        clk;
  logic        rst;
  logic        rst2;
  logic [11:0] lft;
  logic [11:0] rght;
  logic        enSteer;
  logic        riderOff;
  logic [1:0]  steerState;
  logic        enSteer2;
  logic        riderOff2;
  logic [1:0]  steerState2;

  int compareCount  = 0;
  int mismatchCount = 0;

  rider_steer_qual #(.FAST_SIM(1)) dut (
    .clk(clk), .rst(rst), .lft_ld(lft), .rght_ld(rght),
    .en_steer(enSteer), .rider_off(riderOff), .steer_state(steerState)
  );

  rider_steer_qual #(.FAST_SIM(1)) dut2 (
    .clk(clk), .rst(rst2), .lft_ld(lft), .rght_ld(rght),
    .en_steer(enSteer2), .rider_off(riderOff2), .steer_state(steerState2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Holds the given loads for n rising edges; sampling happens 1 ns after the last edge.
  task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r, input int n);
    lft  = l;
    rght = r;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkState(input string tag, input logic [1:0] st);
    checkOutput({tag, ".state"}, {30'd0, steerState}, {30'd0, st});
    checkOutput({tag, ".en"},    {31'd0, enSteer},    {31'd0, (st == 2'd2)});
    checkOutput({tag, ".off"},   {31'd0, riderOff},   {31'd0, (st == 2'd0)});
  endtask

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    rst2 = 1'b1;
    applyStimulus(12'h150, 12'h150, 2);
    checkState("reset", 2'd0);
    checkOutput("reset2.state", {30'd0, steerState2}, 32'd0);

    // Two-edge latency out of reset into QUALIFY.
    rst  = 1'b0;
    rst2 = 1'b0;
    applyStimulus(12'h150, 12'h150, 1);
    checkState("rstRel1", 2'd0);
    applyStimulus(12'h150, 12'h150, 1);
    checkState("rstRel2", 2'd1);

    // Steady balanced rider: STEER exactly 2**15 edges after entering QUALIFY.
    applyStimulus(12'h150, 12'h150, 32767);
    checkState("qualWait", 2'd1);
    applyStimulus(12'h150, 12'h150, 1);
    checkState("qualDone", 2'd2);
    checkOutput("dut2Steer", {30'd0, steerState2}, 32'd2);

    // Reset while steering drops en_steer on the same edge.
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    checkOutput("rstSteer.en",    {31'd0, enSteer2},    32'd0);
    checkOutput("rstSteer.off",   {31'd0, riderOff2},   32'd1);
    checkOutput("rstSteer.state", {30'd0, steerState2}, 32'd0);

    // Sum 0x2A0 gives exit limit 0x276: diff 0x276 holds, diff 0x280 exits.
    applyStimulus(12'h28B, 12'h015, 20);
    checkState("exitEq", 2'd2);
    applyStimulus(12'h290, 12'h010, 1);
    checkState("exitOver1", 2'd2);
    applyStimulus(12'h290, 12'h010, 1);
    checkState("exitOver2", 2'd1);

    // Imbalance above the enter limit keeps the timer cleared.
    applyStimulus(12'h1C0, 12'h0E0, 1000);
    checkState("badEnter", 2'd1);
    applyStimulus(12'h150, 12'h150, 32768);
    checkState("balWait", 2'd1);
    applyStimulus(12'h150, 12'h150, 1);
    checkState("balDone", 2'd2);

    // Sums in the hysteresis band, including the lower threshold itself.
    applyStimulus(12'h0E8, 12'h0E8, 200);
    checkState("band", 2'd2);
    applyStimulus(12'h0E0, 12'h0E0, 10);
    checkState("lowEdge", 2'd2);

    // A one-cycle gap in low weight restarts the debounce.
    applyStimulus(12'h080, 12'h080, 3);
    applyStimulus(12'h150, 12'h150, 1);
    applyStimulus(12'h080, 12'h080, 3);
    applyStimulus(12'h150, 12'h150, 5);
    checkState("gap", 2'd2);

    // Four consecutive low-weight samples declare rider loss.
    applyStimulus(12'h080, 12'h080, 4);
    checkState("lost4", 2'd2);
    applyStimulus(12'h080, 12'h080, 1);
    checkState("lostIdle", 2'd0);

    // Upper threshold is strict.
    applyStimulus(12'h120, 12'h120, 20);
    checkState("eqUpper", 2'd0);
    applyStimulus(12'h121, 12'h120, 1);
    checkState("overUpper1", 2'd0);
    applyStimulus(12'h121, 12'h120, 1);
    checkState("overUpper2", 2'd1);

    // Rider loss while qualifying.
    applyStimulus(12'h080, 12'h080, 4);
    checkState("qualLost4", 2'd1);
    applyStimulus(12'h080, 12'h080, 1);
    checkState("qualLostIdle", 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
